// File: rtl/interrupt_sequencer_pkg.sv
// Shared encodings for the BRK/IRQ/NMI/RESET microsequencer: state codes,
// interrupt kinds, address-select codes and the default vector addresses.
package interrupt_sequencer_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DUMMY    = 3'd1;
  localparam logic [2:0] ST_PUSH_PCH = 3'd2;
  localparam logic [2:0] ST_PUSH_PCL = 3'd3;
  localparam logic [2:0] ST_PUSH_P   = 3'd4;
  localparam logic [2:0] ST_VEC_LO   = 3'd5;
  localparam logic [2:0] ST_VEC_HI   = 3'd6;

  typedef enum logic [1:0] {
    KIND_RESET = 2'd0,
    KIND_NMI   = 2'd1,
    KIND_IRQ   = 2'd2,
    KIND_BRK   = 2'd3
  } kind_t;

  localparam logic [1:0] ADDR_PC     = 2'd0;
  localparam logic [1:0] ADDR_STACK  = 2'd1;
  localparam logic [1:0] ADDR_VECTOR = 2'd2;

  localparam logic [15:0] DEF_VEC_NMI    = 16'hFFFA;
  localparam logic [15:0] DEF_VEC_RESET  = 16'hFFFC;
  localparam logic [15:0] DEF_VEC_IRQ    = 16'hFFFE;
  localparam logic [7:0]  DEF_STACK_PAGE = 8'h01;

  // A pending NMI steals the vector of an IRQ/BRK sequence, never of RESET.
  function automatic logic usesNmiVector(input kind_t kind, input logic pending);
    return (kind == KIND_NMI) || (pending && (kind == KIND_IRQ || kind == KIND_BRK));
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Decoder-side control bundle of the interrupt sequencer; slave is the
// sequencer itself, master is whoever drives SYNC/requests and reads strobes.
interface interrupt_sequencer_if;
  logic        i_sync;
  logic        i_brk_req;
  logic        i_irq_n;
  logic        i_nmi_n;
  logic        i_iflag;
  logic        o_busy;
  logic [1:0]  o_kind;
  logic        o_rw;
  logic [1:0]  o_addr_sel;
  logic [15:0] o_vector_addr;
  logic        o_pch_db_bus_enable;
  logic        o_pcl_db_bus_enable;
  logic        o_psr_bus_enable;
  logic        o_b_flag;
  logic        o_s_dec;
  logic        o_pcl_load_db;
  logic        o_pch_load_db;
  logic        o_i_set;
  logic        o_done;

  modport slave (
    input  i_sync, i_brk_req, i_irq_n, i_nmi_n, i_iflag,
    output o_busy, o_kind, o_rw, o_addr_sel, o_vector_addr,
           o_pch_db_bus_enable, o_pcl_db_bus_enable, o_psr_bus_enable,
           o_b_flag, o_s_dec, o_pcl_load_db, o_pch_load_db, o_i_set, o_done
  );

  modport master (
    output i_sync, i_brk_req, i_irq_n, i_nmi_n, i_iflag,
    input  o_busy, o_kind, o_rw, o_addr_sel, o_vector_addr,
           o_pch_db_bus_enable, o_pcl_db_bus_enable, o_psr_bus_enable,
           o_b_flag, o_s_dec, o_pcl_load_db, o_pch_load_db, o_i_set, o_done
  );
endinterface

// File: rtl/interrupt_sequencer_nmi_edge_latch.sv
// NMI falling-edge detector with a sticky pending flag; a new edge wins over
// a clear arriving on the same clock.
module interrupt_sequencer_nmi_edge_latch (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_nmi_n,
  input  logic i_clear,
  output logic o_pending
);

  logic r_nmiReg;
  logic r_pending;
  logic w_fall;

  always_ff @(posedge i_clk) begin
    r_nmiReg <= i_nmi_n;
  end

  assign w_fall = r_nmiReg & ~i_nmi_n;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_pending <= 1'b0;
    else if (w_fall)
      r_pending <= 1'b1;
    else if (i_clear)
      r_pending <= 1'b0;
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/interrupt_sequencer.sv
// Seven-cycle interrupt/reset microsequencer that owns the register control
// strobes while BUSY is high.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [15:0] VEC_NMI   = DEF_VEC_NMI,
  parameter logic [15:0] VEC_RESET = DEF_VEC_RESET,
  parameter logic [15:0] VEC_IRQ   = DEF_VEC_IRQ
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  interrupt_sequencer_if.slave  bus
);

  logic [2:0]  r_state;
  kind_t       r_kind;
  logic [15:0] r_vector;
  logic        w_pending;
  logic        w_useNmi;
  logic        w_clear;
  logic        w_pushWrite;
  logic [15:0] w_nextVector;

  assign w_useNmi     = usesNmiVector(r_kind, w_pending);
  assign w_clear      = (r_state == ST_PUSH_P) && w_useNmi;
  assign w_nextVector = w_useNmi ? VEC_NMI : ((r_kind == KIND_RESET) ? VEC_RESET : VEC_IRQ);
  assign w_pushWrite  = (r_kind != KIND_RESET);

  interrupt_sequencer_nmi_edge_latch u_nmi (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_nmi_n   (bus.i_nmi_n),
    .i_clear   (w_clear),
    .o_pending (w_pending)
  );

  // The vector is frozen when leaving PUSH_P so a late NMI cannot split lo/hi.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state  <= ST_DUMMY;
      r_kind   <= KIND_RESET;
      r_vector <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_sync) begin
            if (w_pending) begin
              r_state <= ST_DUMMY;
              r_kind  <= KIND_NMI;
            end else if (bus.i_brk_req) begin
              r_state <= ST_DUMMY;
              r_kind  <= KIND_BRK;
            end else if (!bus.i_irq_n && !bus.i_iflag) begin
              r_state <= ST_DUMMY;
              r_kind  <= KIND_IRQ;
            end
          end
        end
        ST_DUMMY:    r_state <= ST_PUSH_PCH;
        ST_PUSH_PCH: r_state <= ST_PUSH_PCL;
        ST_PUSH_PCL: r_state <= ST_PUSH_P;
        ST_PUSH_P: begin
          r_state  <= ST_VEC_LO;
          r_vector <= w_nextVector;
        end
        ST_VEC_LO:   r_state <= ST_VEC_HI;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_kind = r_kind;

  always_comb begin
    bus.o_busy              = 1'b1;
    bus.o_rw                = 1'b1;
    bus.o_addr_sel          = ADDR_PC;
    bus.o_vector_addr       = 16'h0000;
    bus.o_pch_db_bus_enable = 1'b0;
    bus.o_pcl_db_bus_enable = 1'b0;
    bus.o_psr_bus_enable    = 1'b0;
    bus.o_b_flag            = 1'b0;
    bus.o_s_dec             = 1'b0;
    bus.o_pcl_load_db       = 1'b0;
    bus.o_pch_load_db       = 1'b0;
    bus.o_i_set             = 1'b0;
    bus.o_done              = 1'b0;
    if (i_reset_n) begin
      case (r_state)
        ST_IDLE: bus.o_busy = 1'b0;
        ST_PUSH_PCH: begin
          bus.o_addr_sel          = ADDR_STACK;
          bus.o_rw                = ~w_pushWrite;
          bus.o_pch_db_bus_enable = w_pushWrite;
          bus.o_s_dec             = 1'b1;
        end
        ST_PUSH_PCL: begin
          bus.o_addr_sel          = ADDR_STACK;
          bus.o_rw                = ~w_pushWrite;
          bus.o_pcl_db_bus_enable = w_pushWrite;
          bus.o_s_dec             = 1'b1;
        end
        ST_PUSH_P: begin
          bus.o_addr_sel       = ADDR_STACK;
          bus.o_rw             = ~w_pushWrite;
          bus.o_psr_bus_enable = w_pushWrite;
          bus.o_b_flag         = (r_kind == KIND_BRK);
          bus.o_s_dec          = 1'b1;
        end
        ST_VEC_LO: begin
          bus.o_addr_sel    = ADDR_VECTOR;
          bus.o_vector_addr = r_vector;
          bus.o_pcl_load_db = 1'b1;
        end
        ST_VEC_HI: begin
          bus.o_addr_sel    = ADDR_VECTOR;
          bus.o_vector_addr = r_vector + 16'd1;
          bus.o_pch_load_db = 1'b1;
          bus.o_i_set       = 1'b1;
          bus.o_done        = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: each cycle of a sequence is compared
// as one packed snapshot of all outputs against a hand-built expectation.
module tb_interrupt_sequencer;

  logic clk = 1'b0;
  logic rstN;
  int   vectorCount = 0;
  int   miscompareCount = 0;

  always #5 clk = ~clk;

  interrupt_sequencer_if bus ();

  interrupt_sequencer dut (
    .i_clk     (clk),
    .i_reset_n (rstN),
    .bus       (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Layout: {0, busy, kind, rw, addr_sel, pchEn, pclEn, psrEn, b, sDec, pclLd, pchLd, iSet, done, vector}
  function automatic logic [31:0] observedSnap();
    logic [1:0] k;
    k = bus.o_busy ? bus.o_kind : 2'b00;
    return {1'b0, bus.o_busy, k, bus.o_rw, bus.o_addr_sel,
            bus.o_pch_db_bus_enable, bus.o_pcl_db_bus_enable, bus.o_psr_bus_enable,
            bus.o_b_flag, bus.o_s_dec, bus.o_pcl_load_db, bus.o_pch_load_db,
            bus.o_i_set, bus.o_done, bus.o_vector_addr};
  endfunction

  // Stage 0 = idle, 1 = dummy, 2..4 = pushes, 5/6 = vector lo/hi.
  function automatic logic [31:0] expectedSnap(input int stage, input logic [1:0] kind, input logic [15:0] vec);
    logic busy, rw, pch, pcl, psr, b, sDec, pclLd, pchLd, iSet, done, pushW;
    logic [1:0] addr;
    logic [15:0] v;
    busy = 1'b1; rw = 1'b1; addr = 2'd0; v = 16'h0000;
    pch = 0; pcl = 0; psr = 0; b = 0; sDec = 0; pclLd = 0; pchLd = 0; iSet = 0; done = 0;
    pushW = (kind != 2'd0);
    case (stage)
      0: busy = 1'b0;
      2: begin addr = 2'd1; rw = ~pushW; pch = pushW; sDec = 1'b1; end
      3: begin addr = 2'd1; rw = ~pushW; pcl = pushW; sDec = 1'b1; end
      4: begin addr = 2'd1; rw = ~pushW; psr = pushW; b = (kind == 2'd3); sDec = 1'b1; end
      5: begin addr = 2'd2; v = vec; pclLd = 1'b1; end
      6: begin addr = 2'd2; v = vec + 16'd1; pchLd = 1'b1; iSet = 1'b1; done = 1'b1; end
      default: ;
    endcase
    return {1'b0, busy, (busy ? kind : 2'b00), rw, addr, pch, pcl, psr, b, sDec,
            pclLd, pchLd, iSet, done, v};
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sync, input logic brk, input logic irqN, input logic iflag);
    bus.i_sync    = sync;
    bus.i_brk_req = brk;
    bus.i_irq_n   = irqN;
    bus.i_iflag   = iflag;
    stepCycle();
    bus.i_sync    = 1'b0;
    bus.i_brk_req = 1'b0;
  endtask

  // Assumes the current cycle is the DUMMY cycle; optionally drops NMI_N at a stage.
  task automatic runSequence(input string tag, input logic [1:0] kind, input logic [15:0] vec,
                             input int lastStage, input int nmiAt);
    for (int s = 1; s <= lastStage; s++) begin
      if (s > 1) stepCycle();
      checkOutput($sformatf("%s_s%0d", tag, s), observedSnap(), expectedSnap(s, kind, vec));
      if (s == nmiAt) bus.i_nmi_n = 1'b0;
    end
    if (lastStage == 6) begin
      stepCycle();
      checkOutput($sformatf("%s_idle", tag), observedSnap(), expectedSnap(0, kind, vec));
    end
  endtask

  initial begin
    rstN = 1'b0;
    bus.i_sync = 1'b0; bus.i_brk_req = 1'b0; bus.i_irq_n = 1'b1;
    bus.i_nmi_n = 1'b1; bus.i_iflag = 1'b1;

    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput($sformatf("resetHeld%0d", c), observedSnap(), expectedSnap(1, 2'd0, 16'h0));
    end
    rstN = 1'b1;
    runSequence("reset", 2'd0, 16'hFFFC, 6, 0);
    stepCycle();

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    runSequence("brk", 2'd3, 16'hFFFE, 6, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("irqMasked", observedSnap(), expectedSnap(0, 2'd0, 16'h0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    bus.i_irq_n = 1'b1;
    bus.i_iflag = 1'b1;
    runSequence("irq", 2'd2, 16'hFFFE, 6, 0);

    bus.i_nmi_n = 1'b0;
    stepCycle();
    checkOutput("nmiPendIdle", observedSnap(), expectedSnap(0, 2'd0, 16'h0));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    runSequence("nmi", 2'd1, 16'hFFFA, 6, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("nmiOnce", observedSnap(), expectedSnap(0, 2'd0, 16'h0));
    for (int c = 0; c < 10; c++) stepCycle();
    bus.i_nmi_n = 1'b1;
    stepCycle();

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    runSequence("brkNmi", 2'd3, 16'hFFFA, 6, 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("brkNmiOnce", observedSnap(), expectedSnap(0, 2'd0, 16'h0));
    bus.i_nmi_n = 1'b1;
    stepCycle();

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runSequence("irqAbort", 2'd2, 16'hFFFE, 3, 0);
    rstN = 1'b0;
    stepCycle();
    checkOutput("abortHeld0", observedSnap(), expectedSnap(1, 2'd0, 16'h0));
    stepCycle();
    checkOutput("abortHeld1", observedSnap(), expectedSnap(1, 2'd0, 16'h0));
    bus.i_irq_n = 1'b1;
    bus.i_iflag = 1'b1;
    rstN = 1'b1;
    runSequence("resetAfterAbort", 2'd0, 16'hFFFC, 6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
